color_frame_ctrl: RTL and testbench
===================================

// Module: color_frame_ctrl
// PURPOSE
//  Frame-level controller for the per-pixel dominant-colour classifier. Accepts a
//  pixel stream over a valid/ready handshake and classifies every pixel. Tallies
//  per-class votes across one frame (sof..eof), then reports the frame's dominant
//  colour over a result handshake. Sits between video capture and display/LED logic.
// PARAMETERS
//  DATA_WIDTH     8      bits per colour channel
//  BRIGHT_THRESH  50     a pixel is "lit" only if some channel > BRIGHT_THRESH
//  CNT_W          20     vote counter width; counters saturate at 2**CNT_W-1
//  MIN_VOTES      1024   winning class needs >= MIN_VOTES, else result = NONE
//  HYST_FRAMES    2      consecutive agreeing frames needed (HYSTERESIS_EN only)
// PORTS
//  clk           in   1           rising-edge clock
//  reset_n       in   1           asynchronous, active-low reset
//  px_red        in   DATA_WIDTH  pixel red channel
//  px_green      in   DATA_WIDTH  pixel green channel
//  px_blue       in   DATA_WIDTH  pixel blue channel
//  px_sof        in   1           pixel is first of frame
//  px_eof        in   1           pixel is last of frame
//  px_valid      in   1           pixel qualifiers valid
//  px_ready      out  1           controller accepts pixel this cycle
//  res_color     out  2           0=RED 1=GREEN 2=BLUE 3=NONE
//  res_valid     out  1           res_color valid; held until res_ready
//  res_ready     in   1           consumer takes result
//  frame_abort   out  1           1-cycle pulse: sof seen mid-frame, partial frame dropped
// BEHAVIOUR
//  Accept = px_valid & px_ready. Pixel class per accepted pixel, combinational:
//   no channel > BRIGHT_THRESH -> NONE; red>blue: red>green ? RED : GREEN;
//   blue>red: blue>green ? BLUE : GREEN; red==blue -> NONE.
//  FSM: IDLE, ACCUM, DECIDE, REPORT. Reset: IDLE, all counters 0, px_ready=0,
//   res_valid=0, res_color=NONE(3), frame_abort=0.
//  IDLE: px_ready=1. Accepted pixel without sof discarded. Accepted sof: clear
//   counters, count the pixel, -> ACCUM (sof&eof same pixel -> DECIDE directly).
//  ACCUM: px_ready=1. Each accepted pixel increments its class counter (cnt_r,
//   cnt_g, cnt_b, cnt_n), saturating. Accepted eof: count it, -> DECIDE.
//   Accepted sof: pulse frame_abort, clear counters, count pixel as new frame, stay.
//  DECIDE (1 cycle, px_ready=0): winner = strict max of cnt_r/cnt_g/cnt_b; any
//   tie for the max, or max < MIN_VOTES -> NONE. cnt_n never wins. -> REPORT.
//  REPORT: px_ready=0, res_valid=1, res_color stable. res_valid&res_ready -> IDLE,
//   res_valid drops next cycle. No timeout; stream is back-pressured indefinitely.
//  Latency: res_valid rises exactly 2 clk after the cycle eof is accepted.
//  res_color retains last reported value after res_valid falls.
//  Saturated counters stay at max; comparison uses saturated values.
//  reset_n low at any time: immediate return to reset values; partial frame lost.
// CONFIGURATION
//  HYSTERESIS_EN defined: DECIDE feeds a candidate register + agree counter;
//   res_color changes only after HYST_FRAMES consecutive frames with the same
//   winner; until then REPORT presents the previously committed colour (NONE
//   after reset). A result is still reported every frame.
//  HYSTERESIS_EN undefined: every frame reports its own winner directly.
// STRUCTURE
//  Package color_pkg: typedef enum logic [1:0] {RED=0,GREEN=1,BLUE=2,NONE=3}
//   color_e; FSM state enum; BRIGHT_THRESH default constant.
//  Sub-module pixel_classify (combinational r/g/b -> color_e) instantiated once;
//   counters, FSM and decision logic live in color_frame_ctrl.
// TESTING
//  1) 2048 px (200,10,10) sof..eof, res_ready=1 -> res_color=0, res_valid 2 clk after eof.
//  2) 1024 px (10,240,10) + 1024 px (10,10,240) -> tie -> res_color=3.
//  3) 4096 px (20,20,20) (unlit) -> res_color=3; 512 px (0,0,200) only -> 3 (< MIN_VOTES).
//  4) res_ready=0 for 10 clk in REPORT -> res_valid,res_color stable, px_ready=0; then 1-cycle ack.
//  5) sof mid-frame after 100 red px, then 2048 blue + eof -> frame_abort 1 pulse, res_color=2.
//  6) reset_n low mid-ACCUM -> outputs at reset values; HYSTERESIS_EN: frames R,G,G -> 3,3,1.

Source files
------------

// File: rtl/color_pkg.sv
// Shared types and defaults for the dominant-colour frame controller.
package color_pkg;

    typedef enum logic [1:0] {
        RED   = 2'd0,
        GREEN = 2'd1,
        BLUE  = 2'd2,
        NONE  = 2'd3
    } color_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_DECIDE = 2'd2,
        ST_REPORT = 2'd3
    } state_e;

    localparam int BRIGHT_THRESH_DEFAULT = 50;

endpackage

// File: rtl/pixel_classify.sv
// Combinational per-pixel colour class: dark pixels and red==blue pixels map to NONE.
module pixel_classify
    import color_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int BRIGHT_THRESH = BRIGHT_THRESH_DEFAULT
) (
    input  logic [DATA_WIDTH-1:0] red,
    input  logic [DATA_WIDTH-1:0] green,
    input  logic [DATA_WIDTH-1:0] blue,
    output color_e                color
);

    localparam logic [DATA_WIDTH-1:0] THRESH = DATA_WIDTH'(BRIGHT_THRESH);

    logic lit;

    assign lit = (red > THRESH) || (green > THRESH) || (blue > THRESH);

    always_comb begin
        color = NONE;
        if (lit) begin
            if (red > blue) begin
                color = (red > green) ? RED : GREEN;
            end else if (blue > red) begin
                color = (blue > green) ? BLUE : GREEN;
            end
        end
    end

endmodule

// File: rtl/color_frame_ctrl.sv
// Frame-level dominant-colour controller: tallies per-class votes over sof..eof and reports a winner.
// Optional HYSTERESIS_EN macro: the reported colour only changes after HYST_FRAMES agreeing frames.
module color_frame_ctrl
    import color_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int BRIGHT_THRESH = BRIGHT_THRESH_DEFAULT,
    parameter int CNT_W         = 20,
    parameter int MIN_VOTES     = 1024,
    parameter int HYST_FRAMES   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] px_red,
    input  logic [DATA_WIDTH-1:0] px_green,
    input  logic [DATA_WIDTH-1:0] px_blue,
    input  logic                  px_sof,
    input  logic                  px_eof,
    input  logic                  px_valid,
    output logic                  px_ready,
    output logic [1:0]            res_color,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  frame_abort
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_VOTES);

    state_e           state_reg;
    state_e           state_next;
    logic             px_ready_reg;
    logic             res_valid_reg;
    logic             frame_abort_reg;
    color_e           res_color_reg;
    color_e           px_class;
    color_e           winner;
    color_e           report_color;
    logic [1:0]       class_idx;
    logic             accept;
    logic             frame_start;
    logic             count_en;
    logic [CNT_W-1:0] cnt [4];
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_g;
    logic [CNT_W-1:0] cnt_b;
    logic             unused_cnt_n;

    pixel_classify #(
        .DATA_WIDTH   (DATA_WIDTH),
        .BRIGHT_THRESH(BRIGHT_THRESH)
    ) u_classify (
        .red  (px_red),
        .green(px_green),
        .blue (px_blue),
        .color(px_class)
    );

    assign class_idx   = px_class;
    assign accept      = px_valid && px_ready_reg;
    assign frame_start = accept && px_sof;
    // Outside a frame only a sof pixel is counted; inside, every accepted pixel is.
    assign count_en    = frame_start || (accept && (state_reg == ST_ACCUM));

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            logic             hit;

            assign hit = (class_idx == 2'(gi));

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg <= '0;
                end else if (count_en) begin
                    if (frame_start) begin
                        cnt_reg <= hit ? CNT_W'(1) : '0;
                    end else if (hit && (cnt_reg != CNT_MAX)) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign cnt[gi] = cnt_reg;
        end
    endgenerate

    assign cnt_r = cnt[0];
    assign cnt_g = cnt[1];
    assign cnt_b = cnt[2];
    // NONE-class votes are tallied but never compete for the result.
    assign unused_cnt_n = ^cnt[3];

    always_comb begin
        winner = NONE;
        if ((cnt_r > cnt_g) && (cnt_r > cnt_b)) begin
            winner = (cnt_r >= MIN_CNT) ? RED : NONE;
        end else if ((cnt_g > cnt_r) && (cnt_g > cnt_b)) begin
            winner = (cnt_g >= MIN_CNT) ? GREEN : NONE;
        end else if ((cnt_b > cnt_r) && (cnt_b > cnt_g)) begin
            winner = (cnt_b >= MIN_CNT) ? BLUE : NONE;
        end
    end

`ifdef HYSTERESIS_EN
    localparam int AGREE_W = $clog2(HYST_FRAMES + 1);

    color_e             cand_reg;
    color_e             committed_reg;
    logic [AGREE_W-1:0] agree_reg;
    logic [AGREE_W-1:0] agree_next;

    always_comb begin
        agree_next = AGREE_W'(1);
        if (winner == cand_reg) begin
            agree_next = (agree_reg >= AGREE_W'(HYST_FRAMES)) ? agree_reg : agree_reg + 1'b1;
        end
        report_color = (agree_next >= AGREE_W'(HYST_FRAMES)) ? winner : committed_reg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand_reg      <= NONE;
            committed_reg <= NONE;
            agree_reg     <= '0;
        end else if (state_reg == ST_DECIDE) begin
            cand_reg      <= winner;
            agree_reg     <= agree_next;
            committed_reg <= report_color;
        end
    end
`else
    logic [$clog2(HYST_FRAMES + 1)-1:0] unused_hyst;

    assign unused_hyst  = '0;
    assign report_color = winner;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (frame_start) state_next = px_eof ? ST_DECIDE : ST_ACCUM;
            ST_ACCUM:  if (accept && px_eof) state_next = ST_DECIDE;
            ST_DECIDE: state_next = ST_REPORT;
            ST_REPORT: if (res_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // px_ready is registered from the next state so it is low while reset is held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            px_ready_reg    <= 1'b0;
            res_valid_reg   <= 1'b0;
            res_color_reg   <= NONE;
            frame_abort_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            px_ready_reg    <= (state_next == ST_IDLE) || (state_next == ST_ACCUM);
            frame_abort_reg <= frame_start && (state_reg == ST_ACCUM);
            if (state_reg == ST_DECIDE) begin
                res_valid_reg <= 1'b1;
                res_color_reg <= report_color;
            end else if ((state_reg == ST_REPORT) && res_ready) begin
                res_valid_reg <= 1'b0;
            end
        end
    end

    assign px_ready    = px_ready_reg;
    assign res_valid   = res_valid_reg;
    assign res_color   = res_color_reg;
    assign frame_abort = frame_abort_reg;

endmodule

// File: tb/tb_color_frame_ctrl.sv
// Self-checking bench for color_frame_ctrl: frame-level model plus directed frames with literal results.
`ifdef HYSTERESIS_EN
`define PICK(plain, hyst) (hyst)
`else
`define PICK(plain, hyst) (plain)
`endif

module tb_color_frame_ctrl;

    localparam int MIN_VOTES = 1024;
    localparam int THR       = 50;
    localparam int CNT_MAX   = (1 << 20) - 1;
    localparam int HYST      = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] px_red = '0;
    logic [7:0] px_green = '0;
    logic [7:0] px_blue = '0;
    logic       px_sof = 1'b0;
    logic       px_eof = 1'b0;
    logic       px_valid = 1'b0;
    logic       px_ready;
    logic [1:0] res_color;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic       frame_abort;

    typedef struct {
        int color;
        int acc_cyc;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   got_q[$];
    int   cnt_m[4];
    bit   in_frame = 1'b0;
    int   exp_aborts = 0;
    int   n_aborts = 0;
    int   last_color = 3;
    bit   prev_valid = 1'b0;
    bit   prev_ack = 1'b0;
    bit   prev_abort = 1'b0;
`ifdef HYSTERESIS_EN
    int   hist[$];
    int   committed = 3;
`endif

    color_frame_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .px_red     (px_red),
        .px_green   (px_green),
        .px_blue    (px_blue),
        .px_sof     (px_sof),
        .px_eof     (px_eof),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .res_color  (res_color),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .frame_abort(frame_abort)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int model_class(input int r, input int g, input int b);
        if (!(r > THR || g > THR || b > THR)) return 3;
        if (r > b) return (r > g) ? 0 : 1;
        if (b > r) return (b > g) ? 2 : 1;
        return 3;
    endfunction

    function automatic int model_winner();
        int mx   = 0;
        int idx  = 3;
        int nmax = 0;
        for (int k = 0; k < 3; k++) if (cnt_m[k] > mx) begin mx = cnt_m[k]; idx = k; end
        for (int k = 0; k < 3; k++) if (cnt_m[k] == mx) nmax++;
        if (nmax != 1 || mx < MIN_VOTES) return 3;
        return idx;
    endfunction

    task automatic model_report(input int w, output int rep);
`ifdef HYSTERESIS_EN
        bit same = 1'b1;
        hist.push_back(w);
        if (hist.size() > HYST) void'(hist.pop_front());
        if (hist.size() < HYST) same = 1'b0;
        foreach (hist[k]) if (hist[k] != w) same = 1'b0;
        if (same) committed = w;
        rep = committed;
`else
        rep = w;
`endif
    endtask

    task automatic model_reset();
        in_frame = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 4; k++) cnt_m[k] = 0;
`ifdef HYSTERESIS_EN
        hist.delete();
        committed = 3;
`endif
    endtask

    task automatic model_accept(input int r, input int g, input int b, input bit sof, input bit eof);
        int c = model_class(r, g, b);
        if (sof) begin
            if (in_frame) exp_aborts++;
            for (int k = 0; k < 4; k++) cnt_m[k] = 0;
            in_frame = 1'b1;
        end
        if (in_frame) begin
            if (cnt_m[c] < CNT_MAX) cnt_m[c]++;
            if (eof) begin
                exp_t e;
                int   rep;
                model_report(model_winner(), rep);
                e.color   = rep;
                e.acc_cyc = cyc;
                exp_q.push_back(e);
                in_frame = 1'b0;
            end
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_px_ready", px_ready, 0);
            chk("rst_res_valid", res_valid, 0);
            chk("rst_res_color", res_color, 3);
            chk("rst_frame_abort", frame_abort, 0);
            last_color = 3;
            prev_valid = 1'b0;
            prev_ack   = 1'b0;
            prev_abort = 1'b0;
        end else begin
            if (frame_abort) begin
                n_aborts++;
                chk("abort_one_cycle", prev_abort, 0);
            end
            if (prev_ack) chk("valid_drop_after_ack", res_valid, 0);
            if (res_valid) begin
                chk("px_ready_in_report", px_ready, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    chk("res_color", res_color, exp_q[0].color);
                    if (!prev_valid) begin
                        chk("result_latency", cyc - exp_q[0].acc_cyc, 2);
                        got_q.push_back(int'(res_color));
                        $display("frame result %0d: res_color %0d (cycle %0d)", got_q.size(), res_color, cyc);
                    end
                    if (res_ready) begin
                        last_color = exp_q[0].color;
                        void'(exp_q.pop_front());
                    end
                end
            end else if (!prev_ack) begin
                chk("res_color_hold", res_color, last_color);
            end
            prev_valid = res_valid;
            prev_ack   = res_valid && res_ready;
            prev_abort = frame_abort;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_px(input int r, input int g, input int b, input bit sof, input bit eof);
        int guard = 0;
        px_red   = 8'(r);
        px_green = 8'(g);
        px_blue  = 8'(b);
        px_sof   = sof;
        px_eof   = eof;
        px_valid = 1'b1;
        @(negedge clk);
        while (!px_ready && guard < 500) begin
            guard++;
            @(negedge clk);
        end
        if (!px_ready) chk("px_accept_timeout", 0, 1);
        else model_accept(r, g, b, sof, eof);
        @(posedge clk);
        #1;
        px_valid = 1'b0;
        px_sof   = 1'b0;
        px_eof   = 1'b0;
    endtask

    task automatic send_run(input int r, input int g, input int b, input int n,
                            input bit sof_first, input bit eof_last);
        for (int i = 0; i < n; i++) send_px(r, g, b, sof_first && (i == 0), eof_last && (i == n - 1));
    endtask

    task automatic wait_done(input string name);
        int guard = 0;
        while ((exp_q.size() != 0 || res_valid) && guard < 2000) begin
            guard++;
            @(negedge clk);
        end
        chk({name, "_completed"}, (exp_q.size() == 0 && !res_valid) ? 1 : 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_lit(input string name, input int want);
        if (got_q.size() == 0) chk(name, -1, want);
        else chk(name, got_q[$], want);
    endtask

    initial begin
        int guard;
        for (int k = 0; k < 4; k++) cnt_m[k] = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("idle_px_ready", px_ready, 1);
        @(posedge clk);
        #1;

        // Pixels outside a frame are dropped without a result.
        send_run(200, 10, 10, 3, 1'b0, 1'b0);
        send_px(200, 10, 10, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("no_result_outside_frame", got_q.size(), 0);

        send_run(200, 10, 10, 2048, 1'b1, 1'b1);
        wait_done("t1");
        chk_lit("t1_red", `PICK(0, 3));

        send_run(20, 240, 10, 1024, 1'b1, 1'b0);
        send_run(10, 10, 240, 1024, 1'b0, 1'b1);
        wait_done("t2");
        chk_lit("t2_tie", `PICK(3, 3));

        send_run(20, 20, 20, 4096, 1'b1, 1'b1);
        wait_done("t3a");
        chk_lit("t3a_unlit", `PICK(3, 3));
        send_run(0, 0, 200, 512, 1'b1, 1'b1);
        wait_done("t3b");
        chk_lit("t3b_few_votes", `PICK(3, 3));

        res_ready = 1'b0;
        send_run(20, 240, 10, 1100, 1'b1, 1'b1);
        guard = 0;
        while (!res_valid && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        repeat (10) begin
            @(negedge clk);
            chk("t4_hold_valid", res_valid, 1);
            chk("t4_hold_ready", px_ready, 0);
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        wait_done("t4");
        chk_lit("t4_green", `PICK(1, 3));

        send_run(200, 10, 10, 100, 1'b1, 1'b0);
        send_run(10, 10, 240, 2048, 1'b1, 1'b1);
        wait_done("t5");
        chk_lit("t5_blue", `PICK(2, 3));
        chk("t5_abort_model", n_aborts, exp_aborts);
        chk("t5_abort_count", n_aborts, 1);

        // Threshold and MIN_VOTES boundaries.
        send_run(51, 10, 10, 1024, 1'b1, 1'b0);
        send_run(50, 50, 50, 200, 1'b0, 1'b0);
        send_run(60, 10, 60, 300, 1'b0, 1'b1);
        wait_done("b1");
        chk_lit("b1_exact_min_votes", `PICK(0, 3));
        send_run(11, 51, 10, 1023, 1'b1, 1'b1);
        wait_done("b2");
        chk_lit("b2_below_min_votes", `PICK(3, 3));
        send_px(200, 10, 10, 1'b1, 1'b1);
        wait_done("b3");
        chk_lit("b3_single_pixel_frame", `PICK(3, 3));
        send_run(200, 10, 10, 1500, 1'b1, 1'b0);
        send_run(20, 240, 10, 1100, 1'b0, 1'b0);
        send_run(10, 10, 240, 1100, 1'b0, 1'b1);
        wait_done("b4");
        chk_lit("b4_lower_tie_ignored", `PICK(0, 3));

        // Reset in the middle of a frame drops it.
        send_run(200, 10, 10, 300, 1'b1, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_px_ready", px_ready, 0);
        chk("t6_rst_res_valid", res_valid, 0);
        chk("t6_rst_res_color", res_color, 3);
        chk("t6_rst_frame_abort", frame_abort, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        send_run(200, 10, 10, 1100, 1'b1, 1'b1);
        wait_done("t6a");
        chk_lit("t6_frame_r", `PICK(0, 3));
        send_run(20, 240, 10, 1100, 1'b1, 1'b1);
        wait_done("t6b");
        chk_lit("t6_frame_g1", `PICK(1, 3));
        send_run(20, 240, 10, 1100, 1'b1, 1'b1);
        wait_done("t6c");
        chk_lit("t6_frame_g2", `PICK(1, 1));

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
